// File: rtl/time_set_ctrl.sv
// Run/set sequencer for the HH:MM:SS BCD counter chain of the alarm clock.
// Define TIME_SET_DEC_EN to let btn_dec decrement the selected digit.
module time_set_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic        btn_dec,
  input  logic [23:0] cur_time,
  output logic [5:0]  cnt_en,
  output logic        load_en,
  output logic [23:0] load_num,
  output logic        setting,
  output logic [3:0]  edit_sel
);

  typedef enum logic [2:0] {RUN, SET_H1, SET_H0, SET_M1, SET_M0, COMMIT} state_e;

  state_e      state_q, state_d;
  logic        tick_q;
  logic [3:0]  shH1_q, shH0_q, shM1_q, shM0_q;
  logic [3:0]  shH1_d, shH0_d, shM1_d, shM0_d;
  logic [5:0]  cntEn_q, cntEn_d;
  logic        loadEn_q, loadEn_d;
  logic [23:0] loadNum_q, loadNum_d;
  logic        setting_q, setting_d;
  logic [3:0]  editSel_q, editSel_d;

  logic        incEv, decEv;
  logic [3:0]  nextH1, h0Lim;
  logic        s0Max, s1Max, m0Max, m1Max, h0Max, midnight;

`ifdef TIME_SET_DEC_EN
  assign incEv = btn_inc & ~btn_dec;
  assign decEv = btn_dec & ~btn_inc;
`else
  logic unused_dec;
  assign incEv      = btn_inc;
  assign decEv      = 1'b0;
  assign unused_dec = btn_dec;
`endif

  // Wrap-around step of one BCD digit within 0..lim.
  function automatic logic [3:0] stepDigit(input logic [3:0] d, input logic [3:0] lim,
                                           input logic up, input logic down);
    stepDigit = d;
    if (up)
      stepDigit = (d >= lim) ? 4'd0 : d + 4'd1;
    else if (down)
      stepDigit = (d == 4'd0 || d > lim) ? lim : d - 4'd1;
  endfunction

  assign s0Max    = cur_time[3:0]   == 4'd9;
  assign s1Max    = cur_time[7:4]   == 4'd5;
  assign m0Max    = cur_time[11:8]  == 4'd9;
  assign m1Max    = cur_time[15:12] == 4'd5;
  assign h0Max    = cur_time[19:16] == 4'd9;
  assign midnight = cur_time == 24'h235959;
  assign h0Lim    = (shH1_q == 4'd2) ? 4'd3 : 4'd9;
  assign nextH1   = stepDigit(shH1_q, 4'd2, incEv, decEv);

  always_comb begin
    state_d   = state_q;
    shH1_d    = shH1_q;
    shH0_d    = shH0_q;
    shM1_d    = shM1_q;
    shM0_d    = shM0_q;
    cntEn_d   = '0;
    loadEn_d  = 1'b0;
    loadNum_d = loadNum_q;
    setting_d = 1'b0;
    editSel_d = '0;

    case (state_q)
      RUN: begin
        if (btn_mode) begin
          state_d = SET_H1;
          {shH1_d, shH0_d, shM1_d, shM0_d} = cur_time[23:8];
        end
      end
      SET_H1: begin
        if (btn_mode) begin
          state_d = SET_H0;
        end else begin
          shH1_d = nextH1;
          if (nextH1 == 4'd2 && shH0_q > 4'd3) shH0_d = 4'd3;
        end
      end
      SET_H0: begin
        if (btn_mode) state_d = SET_M1;
        else          shH0_d  = stepDigit(shH0_q, h0Lim, incEv, decEv);
      end
      SET_M1: begin
        if (btn_mode) state_d = SET_M0;
        else          shM1_d  = stepDigit(shM1_q, 4'd5, incEv, decEv);
      end
      SET_M0: begin
        if (btn_mode) state_d = COMMIT;
        else          shM0_d  = stepDigit(shM0_q, 4'd9, incEv, decEv);
      end
      COMMIT:  state_d = RUN;
      default: state_d = RUN;
    endcase

    // Tick pipeline: the registered tick is turned into per-digit carries.
    if (state_q == RUN && tick_q) begin
      if (midnight) begin
        cntEn_d   = 6'h3F;
        loadEn_d  = 1'b1;
        loadNum_d = '0;
      end else begin
        cntEn_d = {s0Max & s1Max & m0Max & m1Max & h0Max,
                   s0Max & s1Max & m0Max & m1Max,
                   s0Max & s1Max & m0Max,
                   s0Max & s1Max,
                   s0Max,
                   1'b1};
      end
    end

    if (state_d == COMMIT) begin
      cntEn_d   = 6'h3F;
      loadEn_d  = 1'b1;
      loadNum_d = {shH1_d, shH0_d, shM1_d, shM0_d, 8'h00};
    end

    case (state_d)
      SET_H1:  begin setting_d = 1'b1; editSel_d = 4'b1000; end
      SET_H0:  begin setting_d = 1'b1; editSel_d = 4'b0100; end
      SET_M1:  begin setting_d = 1'b1; editSel_d = 4'b0010; end
      SET_M0:  begin setting_d = 1'b1; editSel_d = 4'b0001; end
      default: begin setting_d = 1'b0; editSel_d = 4'b0000; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      tick_q    <= 1'b0;
      shH1_q    <= '0;
      shH0_q    <= '0;
      shM1_q    <= '0;
      shM0_q    <= '0;
      cntEn_q   <= '0;
      loadEn_q  <= 1'b0;
      loadNum_q <= '0;
      setting_q <= 1'b0;
      editSel_q <= '0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick;
      shH1_q    <= shH1_d;
      shH0_q    <= shH0_d;
      shM1_q    <= shM1_d;
      shM0_q    <= shM0_d;
      cntEn_q   <= cntEn_d;
      loadEn_q  <= loadEn_d;
      loadNum_q <= loadNum_d;
      setting_q <= setting_d;
      editSel_q <= editSel_d;
    end
  end

  assign cnt_en   = cntEn_q;
  assign load_en  = loadEn_q;
  assign load_num = loadNum_q;
  assign setting  = setting_q;
  assign edit_sel = editSel_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Randomized bench for time_set_ctrl against a seconds/digit-array reference model.
// Honours TIME_SET_DEC_EN the same way the design does.
module tb_time_set_ctrl;

  logic        clk = 1'b0;
  logic        rst, tick, btn_mode, btn_inc, btn_dec;
  logic [23:0] cur_time;
  logic [5:0]  cnt_en;
  logic        load_en;
  logic [23:0] load_num;
  logic        setting;
  logic [3:0]  edit_sel;

  int total = 0;
  int bad   = 0;
  int curSec = 0;

  // Reference model: mode 0 = run, 1..4 = editing h1,h0,m1,m0, 5 = commit.
  int          mState = 0;
  int          sh[4];
  int          prevTick = 0;
  logic [5:0]  expCnt = '0;
  logic        expLoad = 1'b0;
  logic [23:0] expNum = '0;

  time_set_ctrl dut (
    .clk(clk), .rst(rst), .tick(tick), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .btn_dec(btn_dec), .cur_time(cur_time), .cnt_en(cnt_en), .load_en(load_en),
    .load_num(load_num), .setting(setting), .edit_sel(edit_sel)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] toBcd(input int t);
    int h, m, s;
    h = t / 3600;
    m = (t / 60) % 60;
    s = t % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  // A counter is enabled exactly when its digit changes on the next second.
  function automatic logic [5:0] changeMask(input int t);
    logic [23:0] a, b;
    logic [5:0]  m;
    a = toBcd(t);
    b = toBcd((t + 1) % 86400);
    for (int i = 0; i < 6; i++) m[i] = (a[4*i +: 4] != b[4*i +: 4]);
    return m;
  endfunction

  function automatic int digitMax(input int idx, input int h1);
    case (idx)
      0:       return 2;
      1:       return (h1 == 2) ? 3 : 9;
      2:       return 5;
      default: return 9;
    endcase
  endfunction

  task automatic editShadow(input int dir);
    int idx, n;
    idx = mState - 1;
    n = digitMax(idx, sh[0]) + 1;
    sh[idx] = (sh[idx] + dir + n) % n;
    if (idx == 0 && sh[0] == 2 && sh[1] > 3) sh[1] = 3;
  endtask

  task automatic modelEdge(input int t, input int m, input int inc, input int dec, input int r);
    int dir;
    if (r != 0) begin
      mState = 0; prevTick = 0;
      for (int i = 0; i < 4; i++) sh[i] = 0;
      expCnt = '0; expLoad = 1'b0; expNum = '0;
      return;
    end
    expCnt = '0;
    expLoad = 1'b0;
    if (prevTick != 0 && mState == 0) begin
      expCnt = changeMask(curSec);
      if (curSec == 86399) begin expLoad = 1'b1; expNum = '0; end
    end
    if (mState == 0) begin
      if (m != 0) begin
        mState = 1;
        sh[0] = (curSec / 3600) / 10;
        sh[1] = (curSec / 3600) % 10;
        sh[2] = ((curSec / 60) % 60) / 10;
        sh[3] = ((curSec / 60) % 60) % 10;
      end
    end else if (mState == 5) begin
      mState = 0;
    end else if (m != 0) begin
      mState++;
      if (mState == 5) begin
        expCnt = 6'h3F;
        expLoad = 1'b1;
        expNum = {4'(sh[0]), 4'(sh[1]), 4'(sh[2]), 4'(sh[3]), 8'h00};
      end
    end else begin
`ifdef TIME_SET_DEC_EN
      dir = (inc != 0 && dec == 0) ? 1 : (dec != 0 && inc == 0) ? -1 : 0;
`else
      dir = (inc != 0) ? 1 : 0;
`endif
      if (dir != 0) editShadow(dir);
    end
    prevTick = t;
  endtask

  task automatic checkOutput(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive at the falling edge, model the rising edge, compare 1 time unit later.
  task automatic applyStimulus(input int t, input int m, input int inc, input int dec, input int r);
    logic [3:0] expSel;
    tick = 1'(t); btn_mode = 1'(m); btn_inc = 1'(inc); btn_dec = 1'(dec); rst = 1'(r);
    cur_time = toBcd(curSec);
    @(posedge clk);
    modelEdge(t, m, inc, dec, r);
    #1;
    expSel = (mState >= 1 && mState <= 4) ? 4'(8 >> (mState - 1)) : 4'd0;
    checkOutput("cnt_en", 24'(cnt_en), 24'(expCnt));
    checkOutput("load_en", 24'(load_en), 24'(expLoad));
    checkOutput("load_num", load_num, expNum);
    checkOutput("setting", 24'(setting), 24'((mState >= 1 && mState <= 4) ? 1 : 0));
    checkOutput("edit_sel", 24'(edit_sel), 24'(expSel));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0);
  endtask

  task automatic tickAndCheck(input int t, input logic [5:0] expEn, input logic expLd);
    curSec = t;
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("dir_tick_en", 24'(cnt_en), 24'(expEn));
    checkOutput("dir_tick_ld", 24'(load_en), 24'(expLd));
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("dir_tick_pulse", 24'(cnt_en), 24'h0);
    idle(1);
  endtask

  function automatic int randomTime();
    int h, m, s;
    h = int'($urandom_range(0, 23));
    m = int'($urandom_range(0, 59));
    s = int'($urandom_range(0, 59));
    case ($urandom_range(0, 3))
      0: ;
      1: s = 59;
      2: begin m = 59; s = 59; end
      default: begin
        m = 59; s = 59;
        case ($urandom_range(0, 3))
          0: h = 23;
          1: h = 9;
          2: h = 19;
          default: h = 8;
        endcase
      end
    endcase
    return h * 3600 + m * 60 + s;
  endfunction

  initial begin
    int op;
    for (int i = 0; i < 4; i++) sh[i] = 0;
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("rst_cnt_en", 24'(cnt_en), 24'h0);
    checkOutput("rst_load", 24'(load_en), 24'h0);
    checkOutput("rst_num", load_num, 24'h0);

    tickAndCheck(9, 6'h03, 1'b0);
    tickAndCheck(8 * 3600 + 3599, 6'h1F, 1'b0);
    tickAndCheck(9 * 3600 + 3599, 6'h3F, 1'b0);
    tickAndCheck(86399, 6'h3F, 1'b1);
    checkOutput("midnight_num", load_num, 24'h0);

    curSec = 12 * 3600 + 34 * 60 + 56;
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("enter_sel", 24'(edit_sel), 24'h8);
    applyStimulus(0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 0, 0);
    checkOutput("commit_ld", 24'(load_en), 24'h1);
    checkOutput("commit_num", load_num, 24'h223400);
    checkOutput("commit_setting", 24'(setting), 24'h0);
    idle(1);
    checkOutput("commit_pulse", 24'(load_en), 24'h0);
    checkOutput("commit_hold", load_num, 24'h223400);

    curSec = 19 * 3600 + 5 * 60;
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0);
    checkOutput("mode_inc_sel", 24'(edit_sel), 24'h2);
    tickAndCheck(curSec, 6'h00, 1'b0);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("mode_inc_num", load_num, 24'h190500);
    idle(1);

    curSec = 17 * 3600 + 42 * 60;
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 0, 0);
    checkOutput("clamp_num", load_num, 24'h234200);
    idle(1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 0, 0);
    checkOutput("m0_sel", 24'(edit_sel), 24'h1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("rst_set_ld", 24'(load_en), 24'h0);
    checkOutput("rst_set_setting", 24'(setting), 24'h0);
    idle(1);
    checkOutput("rst_set_noload", 24'(load_en), 24'h0);

    curSec = 10 * 3600 + 3 * 60;
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 1, 1, 0);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
`ifdef TIME_SET_DEC_EN
    checkOutput("dec_num", load_num, 24'h105300);
`else
    checkOutput("dec_num", load_num, 24'h101300);
`endif
    idle(1);

    for (int n = 0; n < 1500; n++) begin
      op = int'($urandom_range(0, 99));
      if ($urandom_range(0, 3) == 0) curSec = randomTime();
      if (op < 20) begin
        applyStimulus(1, 0, 0, 0, 0);
        idle(3);
      end
      else if (op < 40) applyStimulus(0, 1, 0, 0, 0);
      else if (op < 62) applyStimulus(0, 0, 1, 0, 0);
      else if (op < 72) applyStimulus(0, 0, 0, 1, 0);
      else if (op < 78) applyStimulus(0, 0, 1, 1, 0);
      else if (op < 85) applyStimulus(0, 1, 1, 0, 0);
      else if (op < 88) applyStimulus(0, 1, 0, 1, 0);
      else if (op < 90) applyStimulus(0, 0, 0, 0, 1);
      else idle(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
